// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// fwd_hazard_unit : operand forwarding select and load-use / RAW stall unit
//   with a DEPTH-slot shadow pipeline (slot 0 = EXE .. slot DEPTH-1 = WB).
//   Optional macro FWD_PERF_CNT_EN adds stall_cnt / fwd_cnt counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_hazard_unit #(
  parameter int AW      = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fwd_en,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [AW-1:0]         id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  output logic [NUM_SRC*SW-1:0] sel_src,
  output logic                  stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           fwd_cnt
`endif
);

  logic                  valid_q [DEPTH];
  logic [AW-1:0]         dest_q  [DEPTH];
  logic                  wb_q    [DEPTH];
  logic                  mr_q    [DEPTH];
  logic [NUM_SRC*AW-1:0] src_q;
  logic [NUM_SRC-1:0]    src_used_q;

  logic                  valid_d;
  logic [NUM_SRC-1:0]    src_used_d;

  assign valid_d    = id_valid & ~stall & ~flush;
  assign src_used_d = valid_d ? id_src_used : '0;

  // Descending scan so the youngest (smallest k) producer is written last.
  always_comb begin
    sel_src = '0;
    if (fwd_en) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int k = DEPTH - 1; k >= 1; k--) begin
          if (valid_q[k] && wb_q[k] && src_used_q[i] &&
              (dest_q[k] == src_q[i*AW +: AW])) begin
            sel_src[i*SW +: SW] = SW'(k);
          end
        end
      end
    end
  end

  // WB is never checked: the register file writes through to ID.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int k = 0; k < DEPTH - 1; k++) begin
          if (valid_q[k] && wb_q[k] && id_src_used[i] &&
              (dest_q[k] == id_src[i*AW +: AW]) &&
              (fwd_en ? ((k == 0) && mr_q[k]) : 1'b1)) begin
            stall = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        dest_q[k]  <= '0;
        wb_q[k]    <= 1'b0;
        mr_q[k]    <= 1'b0;
      end
      src_q      <= '0;
      src_used_q <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        dest_q[k]  <= dest_q[k-1];
        wb_q[k]    <= wb_q[k-1];
        mr_q[k]    <= mr_q[k-1];
      end
      valid_q[0] <= valid_d;
      dest_q[0]  <= id_dest;
      wb_q[0]    <= id_wb_en;
      mr_q[0]    <= id_mem_read;
      src_q      <= id_src;
      src_used_q <= src_used_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] fwd_inc_d;
  logic [32:0] fwd_sum_d;

  always_comb begin
    fwd_inc_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_src[i*SW +: SW] != '0) fwd_inc_d = fwd_inc_d + 32'd1;
    end
  end

  assign fwd_sum_d = {1'b0, fwd_cnt} + {1'b0, fwd_inc_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      fwd_cnt <= fwd_sum_d[32] ? 32'hFFFF_FFFF : fwd_sum_d[31:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// Randomized bench for fwd_hazard_unit; reference keeps in-flight instructions
// in a queue (index 0 = youngest = EXE) and derives hazards from that history.
`default_nettype none

module tb_fwd_hazard_unit;
  localparam int AW      = 4;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 5;
  localparam int SW      = $clog2(DEPTH);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  fwd_en, flush, id_valid, id_wb_en, id_mem_read;
  logic [AW-1:0]         id_dest;
  logic [NUM_SRC*AW-1:0] id_src;
  logic [NUM_SRC-1:0]    id_src_used;
  logic [NUM_SRC*SW-1:0] sel_src;
  logic                  stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]           stall_cnt, fwd_cnt;
  longint                m_stall_cnt, m_fwd_cnt;
`endif

  fwd_hazard_unit #(.AW(AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .id_valid(id_valid),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_src(id_src), .id_src_used(id_src_used), .sel_src(sel_src), .stall(stall)
`ifdef FWD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                  valid;
    logic [AW-1:0]         dest;
    logic                  wb;
    logic                  mr;
    logic [NUM_SRC*AW-1:0] src;
    logic [NUM_SRC-1:0]    used;
  } instr_t;

  instr_t pipe[$];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back('0);
  endfunction

  // Youngest in-flight writer older than EXE that the EXE operand depends on.
  function automatic int exp_sel(input int i);
    if (!fwd_en || !pipe[0].used[i]) return 0;
    for (int age = 1; age < DEPTH; age++)
      if (pipe[age].valid && pipe[age].wb && pipe[age].dest == pipe[0].src[i*AW +: AW])
        return age;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (flush || !id_valid) return 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!id_src_used[i]) continue;
      if (fwd_en) begin
        if (pipe[0].valid && pipe[0].wb && pipe[0].mr &&
            pipe[0].dest == id_src[i*AW +: AW]) return 1'b1;
      end else begin
        for (int age = 0; age <= DEPTH - 2; age++)
          if (pipe[age].valid && pipe[age].wb &&
              pipe[age].dest == id_src[i*AW +: AW]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_all(input string phase);
    int nz;
    nz = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      check($sformatf("%s_sel%0d", phase, i), sel_src[i*SW +: SW], exp_sel(i));
      if (exp_sel(i) != 0) nz++;
    end
    check({phase, "_stall"}, stall, exp_stall());
`ifdef FWD_PERF_CNT_EN
    check({phase, "_stall_cnt"}, stall_cnt, m_stall_cnt);
    check({phase, "_fwd_cnt"}, fwd_cnt, m_fwd_cnt);
`endif
  endtask

  task automatic model_step();
    instr_t e;
    bit     st;
    int     nz;
    st = exp_stall();
    nz = 0;
    for (int i = 0; i < NUM_SRC; i++) if (exp_sel(i) != 0) nz++;
`ifdef FWD_PERF_CNT_EN
    if (st && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
    m_fwd_cnt = (m_fwd_cnt + nz > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_fwd_cnt + nz;
`endif
    e = '0;
    if (id_valid && !st && !flush) begin
      e.valid = 1'b1;  e.dest = id_dest;  e.wb = id_wb_en;  e.mr = id_mem_read;
      e.src = id_src;  e.used = id_src_used;
    end
    pipe.push_front(e);
    void'(pipe.pop_back());
  endtask

  task automatic drive_random();
    if ($urandom_range(0, 19) == 0) fwd_en = ~fwd_en;
    flush       = ($urandom_range(0, 11) == 0);
    id_valid    = ($urandom_range(0, 7) != 0);
    id_wb_en    = ($urandom_range(0, 4) != 0);
    id_mem_read = ($urandom_range(0, 2) == 0);
    id_dest     = AW'($urandom_range(0, 5));
    for (int i = 0; i < NUM_SRC; i++) id_src[i*AW +: AW] = AW'($urandom_range(0, 5));
    id_src_used = NUM_SRC'($urandom);
  endtask

  initial begin
    rst = 1'b1;  fwd_en = 1'b1;  flush = 1'b0;  id_valid = 1'b0;
    id_wb_en = 1'b0;  id_mem_read = 1'b0;  id_dest = '0;  id_src = '0;  id_src_used = '0;
`ifdef FWD_PERF_CNT_EN
    m_stall_cnt = 0;  m_fwd_cnt = 0;
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) begin
        // Asynchronous reset in the middle of a cycle, inputs left hazardous.
        rst = 1'b1;
        model_clear();
`ifdef FWD_PERF_CNT_EN
        m_stall_cnt = 0;  m_fwd_cnt = 0;
`endif
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
      end
      drive_random();
      #1;
      check_all("run");
      @(posedge clk);
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-source forwarding logic.
- Tracks in-flight writers internally in a DEPTH-slot shadow pipeline: slot 0 = EXE, slot 1 = MEM, …, slot DEPTH-1 = WB.
- Produces per-source forwarding selects for the instruction in EXE, plus the load-use stall for the instruction in ID.
- Adds a runtime no-forwarding mode, which stalls on any RAW hazard instead of forwarding.

Parameters:
- AW, 4, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- DEPTH, 3, tracked slots from EXE to WB inclusive; legal range 3..8.
- SW, $clog2(DEPTH), width of one select field (derived; not to be overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- flush  in  1  discard the ID instruction this cycle (taken branch).
- id_valid  in  1  ID holds a real instruction.
- id_dest  in  AW  ID destination register.
- id_wb_en  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- id_src  in  NUM_SRC*AW  ID source registers; source i is at [i*AW +: AW].
- id_src_used  in  NUM_SRC  per-source "operand actually read" flag.
- sel_src  out  NUM_SRC*SW  per EXE source: 0 = register file, k = forward from slot k (1..DEPTH-1).
- stall  out  1  hold PC and IF/ID; the unit inserts a bubble into EXE.

Behaviour:
- **Slot contents:** each slot holds {valid, dest, wb_en, mem_read}. The EXE entry additionally holds {src[NUM_SRC], src_used[NUM_SRC]}.
- **Reset:**
  - All slot valid bits, EXE src/src_used, and sel_src cleared to 0.
  - stall = 0.
  - Reset is honoured mid-operation with no residue; the first post-reset cycle sees all slots empty.
- **Per rising edge (not in reset):**
  - Slot k <= slot k-1 for k = 1..DEPTH-1; slot DEPTH-1 contents are dropped.
  - Slot 0 loads the ID fields when id_valid & !stall & !flush. Otherwise it loads a bubble (valid = 0, src_used = 0).
- **Match definition:** a slot matches source i when all of:
  - slot valid & wb_en;
  - the source's used flag is set;
  - slot dest == source register.
- **sel_src:**
  - Combinational from slot state only; no combinational path from any id_* input.
  - fwd_en = 1: sel for EXE source i = the smallest k in 1..DEPTH-1 whose slot matches (youngest producer wins); 0 if none.
  - fwd_en = 0: all sel fields = 0.
- **stall (combinational), forced 0 when flush = 1 or id_valid = 0:**
  - fwd_en = 1: stall = 1 iff some used ID source matches slot 0 and slot 0 mem_read = 1 (load-use). This is exactly one stall cycle per load-use pair.
  - fwd_en = 0: stall = 1 iff some used ID source matches any slot 0..DEPTH-2. WB (slot DEPTH-1) is excluded because the register file writes through.
  - Stall repeats every cycle until the hazard clears.
- **Simultaneous events:**
  - flush with a hazard present: no stall; bubble into slot 0.
  - fwd_en changing mid-stream takes effect the same cycle; no state depends on it.
- **Widths:**
  - Register compare is an exact AW-bit equality.
  - sel value k < DEPTH always; the value DEPTH..2^SW-1 is never driven.

Optional Feature:
- **Macro FWD_PERF_CNT_EN**, when defined:
  - Adds output stall_cnt [31:0] and output fwd_cnt [31:0].
  - stall_cnt increments on each cycle stall = 1.
  - fwd_cnt increments by the number of EXE sources with non-zero sel in that cycle.
  - Both are reset to 0 by rst; both saturate at 32'hFFFFFFFF.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

Test Plan:
- **Forwarding from MEM:** fwd_en = 1; issue ADD R3 (wb_en), then SUB with src0 = R3, src1 = R5 → when SUB is in EXE, sel_src = {src1 = 0, src0 = 1}; stall never asserted.
- **Load-use:** LDR R2 followed by ADD src1 = R2 → stall = 1 for exactly 1 cycle, then slot 0 holds a bubble; next cycle, with ADD in EXE, sel for src1 = 2 (WB).
- **Priority:** writes to R4 in consecutive cycles, then a reader of R4 → sel = 1 (younger), not 2; with DEPTH = 5, a producer three instructions back gives sel = 3.
- **Stall-only mode:** fwd_en = 0; ADD R1, then a reader of R1 → stall held 2 cycles (DEPTH = 3); sel_src always 0; a reader with src_used = 0 for R1 → no stall.
- **Flush and reset:** load-use hazard with flush = 1 → stall = 0, bubble into EXE; assert rst mid-stream → sel_src = 0 and stall = 0 immediately (asynchronous), with no forwarding to post-reset instructions.
- **Performance counters (FWD_PERF_CNT_EN):** the load-use sequence gives stall_cnt = 1; two-source forwarding in one cycle gives fwd_cnt += 2.
